// File: rtl/aes_128_decrypt.sv
// aes_128_decrypt: iterative AES-128 inverse cipher, one round per clock; optional key cache under AES_DEC_KEY_CACHE_EN.
// Latency: 21 enabled clocks from accept to Dout_valid (11 on a key-cache hit when AES_DEC_KEY_CACHE_EN is defined).
// Backpressure: Din_ready is low while a block is in flight; Din_valid is ignored (never buffered) until IDLE.
module aes_128_decrypt (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [127:0] Din,
  input  logic [127:0] Key,
  input  logic         Din_valid,
  output logic         Din_ready,
  output logic [127:0] Dout,
  output logic         Dout_valid
);

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDK, ROUND, FINAL} fsm_t;

  fsm_t         fsm;
  logic [3:0]   cnt;
  logic [127:0] st;
  logic [127:0] rk;
  logic [7:0]   rcon;
  logic         rdy_q;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01; p = a;
    repeat (7) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] i;
    i = ginv(b);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Division by x in GF(2^8); odd values had bit 7 set before the xtime reduction.
  function automatic logic [7:0] rdiv(input logic [7:0] a);
    return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
  endfunction

  // Byte i of a block sits at bits [127-8i -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = a[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(a[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] a);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = a[127-32*c -: 8]; a1 = a[119-32*c -: 8];
      a2 = a[111-32*c -: 8]; a3 = a[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  // One set of four forward S-boxes serves both directions of the key schedule.
  logic [31:0]  w0, w1, w2, w3, sw_in, sw_out, f0, f1, f2, f3;
  logic [127:0] rk_fwd, rk_inv, isb, round_out;

  assign {w0, w1, w2, w3} = rk;
  assign sw_in  = (fsm == KEYEXP) ? w3 : (w3 ^ w2);
  assign sw_out = sub_word({sw_in[23:0], sw_in[31:24]});
  assign f0     = w0 ^ sw_out ^ {rcon, 24'h0};
  assign f1     = w1 ^ f0;
  assign f2     = w2 ^ f1;
  assign f3     = w3 ^ f2;
  assign rk_fwd = {f0, f1, f2, f3};
  assign rk_inv = {w0 ^ sw_out ^ {rcon, 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  assign isb       = inv_sub_bytes(inv_shift_rows(st));
  assign round_out = inv_mix_columns(isb ^ rk);
  assign Din_ready = rdy_q & enable;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] ck_tag, ck_rk;
  logic         ck_vld, hit;
  assign hit = ck_vld && (Key == ck_tag);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm        <= IDLE;
      cnt        <= '0;
      st         <= '0;
      rk         <= '0;
      rcon       <= 8'h01;
      rdy_q      <= 1'b0;
      Dout       <= '0;
      Dout_valid <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      ck_tag     <= '0;
      ck_rk      <= '0;
      ck_vld     <= 1'b0;
`endif
    end else begin
      Dout_valid <= 1'b0;
      if (enable) begin
        case (fsm)
          IDLE: begin
            rdy_q <= 1'b1;
            if (Din_valid && rdy_q) begin
              st    <= Din;
              cnt   <= '0;
              rdy_q <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
              if (hit) begin
                rk   <= ck_rk;
                rcon <= 8'h36;
                fsm  <= ADDK;
              end else begin
                rk     <= Key;
                rcon   <= 8'h01;
                fsm    <= KEYEXP;
                ck_tag <= Key;
                ck_vld <= 1'b0;
              end
`else
              rk   <= Key;
              rcon <= 8'h01;
              fsm  <= KEYEXP;
`endif
            end
          end
          KEYEXP: begin
            rk  <= rk_fwd;
            cnt <= cnt + 4'd1;
            // Rcon stays at 0x36 after the last step so the backward walk starts from it.
            if (cnt == 4'd9) begin
              fsm <= ADDK;
`ifdef AES_DEC_KEY_CACHE_EN
              ck_rk  <= rk_fwd;
              ck_vld <= 1'b1;
`endif
            end else begin
              rcon <= xt(rcon);
            end
          end
          ADDK: begin
            st   <= st ^ rk;
            rk   <= rk_inv;
            rcon <= rdiv(rcon);
            cnt  <= '0;
            fsm  <= ROUND;
          end
          ROUND: begin
            st   <= round_out;
            rk   <= rk_inv;
            rcon <= rdiv(rcon);
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd8) fsm <= FINAL;
          end
          FINAL: begin
            Dout       <= isb ^ rk;
            Dout_valid <= 1'b1;
            rdy_q      <= 1'b1;
            fsm        <= IDLE;
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Bench for aes_128_decrypt: an independent AES-128 encryption model produces ciphertext; Dout must return the plaintext.
// Expected latency is 21 clocks plus stalls, or 11 on a key-cache hit when AES_DEC_KEY_CACHE_EN is defined.
module tb_aes_128_decrypt;

  logic         clk = 1'b0;
  logic         reset, enable, Din_valid, Din_ready, Dout_valid;
  logic [127:0] Din, Key, Dout;

  always #5 clk = ~clk;

  aes_128_decrypt dut (
    .clk(clk), .reset(reset), .enable(enable), .Din(Din), .Key(Key),
    .Din_valid(Din_valid), .Din_ready(Din_ready), .Dout(Dout), .Dout_valid(Dout_valid)
  );

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  typedef struct {
    logic [127:0] pt;
    int           acc;
    int           lat;
  } exp_t;

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic         prev_dv = 1'b0;
  logic [127:0] mdl_dout = '0;
  logic [7:0]   sbox [256];
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] mdl_ck_key = '0;
  logic         mdl_ck_vld = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box table from the multiply-by-3 / divide-by-3 generator walk over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    repeat (255) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        a0 = tmp[0];
        tmp[0] = sbox[tmp[1]] ^ rc;
        tmp[1] = sbox[tmp[2]];
        tmp[2] = sbox[tmp[3]];
        tmp[3] = sbox[a0];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare process: every non-reset cycle checks either the new result or that Dout holds.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_dout", Dout, '0);
      chk("rst_dout_valid", 128'(Dout_valid), '0);
      chk("rst_din_ready", 128'(Din_ready), '0);
    end else begin
      if (Dout_valid) begin
        chk("single_pulse", 128'(prev_dv), '0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_dout_valid: got Dout %h with no block in flight, want no pulse", Dout);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dout", Dout, mon_e.pt);
          chk("latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
          mdl_dout = mon_e.pt;
        end
      end else begin
        chk("dout_hold", Dout, mdl_dout);
      end
      if (!enable) chk("valid_while_stalled", 128'(Dout_valid), '0);
    end
    prev_dv = Dout_valid;
  end

  task automatic send(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt, input int stall);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    while (!Din_ready && n < 400) begin
      tick();
      n++;
    end
    if (!Din_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: Din_ready %b after %0d cycles, want 1", Din_ready, n);
      return;
    end
    lat = 21 + stall;
`ifdef AES_DEC_KEY_CACHE_EN
    if (mdl_ck_vld && k == mdl_ck_key) lat = 11 + stall;
    mdl_ck_key = k;
    mdl_ck_vld = 1'b1;
`endif
    Key = k; Din = ct; Din_valid = 1'b1;
    tick();
    Din_valid = 1'b0; Din = rnd128(); Key = rnd128();
    e.pt = pt; e.acc = cyc; e.lat = lat;
    exp_q.push_back(e);
    chk("ready_drop", 128'(Din_ready), '0);
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: %0d results outstanding after %0d cycles, want 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    mdl_dout = '0;
`ifdef AES_DEC_KEY_CACHE_EN
    mdl_ck_vld = 1'b0;
`endif
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("ready_after_reset", 128'(Din_ready), 128'(1));
    chk("dout_after_reset", Dout, '0);
    chk("valid_after_reset", 128'(Dout_valid), '0);
  endtask

  initial begin
    logic [127:0] k, pt;
    reset = 1'b1; enable = 1'b1; Din_valid = 1'b0; Din = '0; Key = '0;
    build_sbox();
    chk("model_sbox_53", 128'(sbox[8'h53]), 128'(8'hed));
    chk("model_enc_vec1", aes_enc(K1, P1), C1);
    chk("model_enc_vec2", aes_enc(K2, P2), C2);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("ready_after_por", 128'(Din_ready), 128'(1));

    send(K1, C1, P1, 0);
    wait_done(60);
    send(K2, C2, P2, 0);
    wait_done(60);

    // Same key twice back-to-back, then a different key.
    send(K1, C1, P1, 0);
    send(K1, C1, P1, 0);
    wait_done(80);
    send(K2, C2, P2, 0);
    wait_done(60);

    // Reset while ROUND is running; K2 is the cached key in the cache build.
    send(K2, C2, P2, 0);
`ifdef AES_DEC_KEY_CACHE_EN
    repeat (6) tick();
`else
    repeat (14) tick();
`endif
    do_reset();
    repeat (3) tick();
    send(K2, C2, P2, 0);
    wait_done(60);

    // Five disabled clocks inside ROUND (K1 misses in both builds here).
    send(K1, C1, P1, 5);
    repeat (14) tick();
    enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    wait_done(60);

    // New data offered while busy must be dropped.
    send(K2, C2, P2, 0);
    Din_valid = 1'b1; Din = C1; Key = K1;
    repeat (8) tick();
    Din_valid = 1'b0;
    wait_done(60);
    repeat (30) tick();

    for (int b = 0; b < 1000; b++) begin
      k  = rnd128();
      pt = rnd128();
      send(k, aes_enc(k, pt), pt, 0);
    end
    wait_done(80);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
